// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU types and constants. The fetch stage uses the word type, the
// fetch FSM state encoding, the PC increment and a word-alignment helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; drop the byte offset.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg
// 32-bit register with asynchronous active-low reset and load enable.
// Holds the program counter here; also reused by the pipeline latches.
//
// Ports:
//   CLK     in   clock, rising edge
//   nRST    in   asynchronous active-low reset (loads PC_INIT)
//   load_i  in   load enable
//   d_i     in   value loaded when load_i=1
//   q_o     out  registered value
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load_i,
    input  word_t d_i,
    output word_t q_o
);

    word_t val_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            val_q <= PC_INIT;
        end else if (load_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding the IF/ID latch. Owns the PC, issues
// instruction reads, delivers each fetched word with its next-PC, and
// handles stalls, redirects (including one arriving while a read is still
// outstanding) and halt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal fetching, one delivery per ihit when not stalled
// PENDING | redirect captured in pend_pc, old read still outstanding
// HALTED  | fetching stopped, PC frozen; only reset leaves this state
//
// Ports:
//   CLK, nRST      clock / asynchronous active-low reset
//   ihit           memory returned imemload for imemaddr this cycle
//   imemload       instruction word from memory
//   stall          hazard unit hold
//   redirect       one-cycle branch/jump redirect pulse, target redirect_pc
//   halt           one-cycle pulse: stop fetching
//   iREN           instruction read enable
//   imemaddr       current PC
//   imemaddr_if    PC+4 of the delivered word (to IF/ID)
//   imemload_if    delivered word (to IF/ID)
//   if_valid       delivery strobe (IF/ID enable)
//   flush_req      redirect accepted this cycle (IF/ID flush)
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  iREN,
    output word_t imemaddr,
    output word_t imemaddr_if,
    output word_t imemload_if,
    output logic  if_valid,
    output logic  flush_req
);

    fetch_state_t state_q, state_d;
    word_t        pend_pc_q, pend_pc_d;
    word_t        pc_q, pc_d;
    logic         pc_load;
    word_t        target_pc;

    assign target_pc = align_word(redirect_pc);

    pc_reg #(
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .CLK    (CLK),
        .nRST   (nRST),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next state / next PC
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pc_d      = pc_q;
        pc_load   = 1'b0;

        if (state_q != HALTED && halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect) begin
                        if (ihit) begin
                            pc_d    = target_pc;
                            pc_load = 1'b1;
                        end else begin
                            // Read still outstanding: keep imemaddr stable
                            // until it completes, then jump.
                            pend_pc_d = target_pc;
                            state_d   = PENDING;
                        end
                    end else if (ihit && !stall) begin
                        pc_d    = pc_q + PC_STEP;
                        pc_load = 1'b1;
                    end
                end
                PENDING: begin
                    if (redirect) begin
                        pend_pc_d = target_pc;
                    end
                    if (ihit) begin
                        // The returned word belongs to the flushed path.
                        pc_d    = redirect ? target_pc : pend_pc_q;
                        pc_load = 1'b1;
                        state_d = RUN;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        iREN      = 1'b0;
        if_valid  = 1'b0;
        flush_req = 1'b0;
        case (state_q)
            RUN: begin
                iREN      = 1'b1;
                if_valid  = ihit && !stall && !redirect && !halt;
                flush_req = redirect && !halt;
            end
            PENDING: begin
                iREN      = 1'b1;
                flush_req = redirect && !halt;
            end
            default: begin
                iREN = 1'b0;
            end
        endcase
    end

    assign imemaddr    = pc_q;
    assign imemaddr_if = pc_q + PC_STEP;
    assign imemload_if = imemload;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the IF/ID latch. Owns the program counter, issues instruction reads to the icache/memory, and presents each fetched word with its next-PC to the IF/ID latch. It handles stalls from the hazard unit, control-flow redirects from later stages (including a redirect that arrives while a fetch is outstanding), and halt.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports (word_t is the 32-bit type from cpu_types_pkg):
- CLK  in  1  rising-edge clock.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory returned imemload for imemaddr this cycle.
- imemload  in  32  instruction word from memory.
- stall  in  1  hazard unit: hold PC, deliver nothing.
- redirect  in  1  one-cycle pulse from branch/jump resolution.
- redirect_pc  in  32  target PC, valid with redirect.
- halt  in  1  one-cycle pulse: stop fetching.
- iREN  out  1  instruction read enable.
- imemaddr  out  32  current PC (word-aligned).
- imemaddr_if  out  32  PC+4 of the delivered instruction, to IF/ID.
- imemload_if  out  32  delivered instruction, to IF/ID.
- if_valid  out  1  delivery strobe; drives the IF/ID enable.
- flush_req  out  1  asserted in the cycle a redirect is accepted; drives the IF/ID flush.

## Operation
- States: RUN, PENDING (redirect captured, old fetch outstanding), HALTED.
- Reset: pc=PC_INIT, state=RUN, pend_pc=0. Outputs after reset: iREN=1, imemaddr=PC_INIT, if_valid=0, flush_req=0, imemaddr_if=PC_INIT+4, imemload_if=imemload.
- iREN=1 in RUN and PENDING and 0 in HALTED. imemaddr=pc at all times. imemaddr_if=pc+4 (32-bit, wraps mod 2^32). imemload_if=imemload.
- RUN, ihit=1, stall=0, no redirect: if_valid=1; pc<=pc+4.
- RUN, stall=1, no redirect: if_valid=0; pc holds even on ihit, and the same address is re-requested.
- RUN, redirect with ihit=1: pc<=redirect_pc; if_valid=0; flush_req=1. Redirect overrides stall.
- RUN, redirect with ihit=0: pend_pc<=redirect_pc; flush_req=1; state<=PENDING. imemaddr stays stable until the outstanding read completes.
- PENDING, ihit=1: the returned word is discarded (if_valid=0); pc<=pend_pc; state<=RUN.
- PENDING, new redirect: pend_pc is overwritten (the newest redirect wins); flush_req=1. If ihit is also 1, pc<=redirect_pc and state<=RUN.
- halt in any state: state<=HALTED; if_valid=0. halt has priority over redirect and ihit in the same cycle.
- HALTED: pc frozen, iREN=0, if_valid=0, flush_req=0. Only nRST exits this state.
- redirect_pc[1:0]≠0: the low two bits are forced to 0.
- nRST low mid-fetch: immediate return to the reset values. A pending redirect is lost.

## Timing
- if_valid, flush_req, and imemaddr_if are combinational from the state and inputs in the same cycle. The IF/ID latch captures them on the next CLK edge.
- PC update takes effect on the CLK edge following ihit or redirect. The new imemaddr is visible one cycle after acceptance.
- Fetch-to-delivery latency: 0 cycles beyond ihit. Throughput: one instruction per ihit cycle.
- Redirect penalty: 1 cycle if ihit=1, otherwise the remaining miss time plus 1 cycle.

## Structure
- Add to cpu_types_pkg: typedef enum logic [1:0] fetch_state_t {RUN, PENDING, HALTED}. Also add constant PC_STEP = 32'd4.
- Registers: pc, pend_pc, state. The next-state/next-PC logic is a single always_comb block.
- There is one natural sub-module, pc_reg: a 32-bit async-reset register with load enable and PC_INIT parameter. It is also reused by the later pipeline latches.
- Integrated as fetch_unit in datapath, wired to if_id_if via imemaddr_if, imemload_if, enable (=if_valid) and flush (=flush_req).

## Test plan
- Reset, then ihit held high 4 cycles with imemload=32'h2001_0001..4 -> imemaddr 0,4,8,C. if_valid=1 each cycle, and imemaddr_if=4,8,C,10.
- ihit=1 with stall=1 for 2 cycles at pc=8 -> if_valid=0 and imemaddr stays 8. After release, the word at 8 is delivered with imemaddr_if=C.
- pc=10, ihit=1, redirect=1, redirect_pc=40 -> flush_req=1, if_valid=0, and next imemaddr=40.
- pc=10, ihit=0, redirect to 80, then ihit after 3 cycles -> PENDING held 3 cycles with imemaddr=10 throughout. The returned word is dropped (if_valid=0), then imemaddr=80.
- In PENDING, a second redirect to C0 arrives before ihit -> the fetch resumes at C0, not 80.
- halt and redirect in the same cycle -> HALTED, iREN=0, pc frozen for 10 cycles. Then nRST pulse -> imemaddr=PC_INIT and iREN=1.
